// File: rtl/i2c_reg_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_reg_seq_if
//  Description : Bundle of the i2c_reg_seq host request/response signals and
//                the command/status handshake towards i2c_master.
//                Ports (by group):
//                  request   : req_vld, req_rdy, req_rd, req_sla, req_reg, req_len
//                  write data: wr_dat, wr_vld, wr_rdy
//                  read data : rd_dat, rd_vld
//                  result    : done, err, err_stat
//                  master    : m_cmd, m_dat, m_ws, m_stat, m_dat_out
//                Modport 'slave' is the sequencer view; modport 'master' is
//                the view of everything around it (host + i2c_master).
//  Revision    : 1.0  initial release
// ============================================================================
interface i2c_reg_seq_if #(
   parameter int LEN_W = 8,
   parameter int C_SZ  = 6,
   parameter int S_SZ  = 4
);
   logic             req_vld;
   logic             req_rdy;
   logic             req_rd;
   logic [6:0]       req_sla;
   logic [7:0]       req_reg;
   logic [LEN_W-1:0] req_len;
   logic [7:0]       wr_dat;
   logic             wr_vld;
   logic             wr_rdy;
   logic [7:0]       rd_dat;
   logic             rd_vld;
   logic             done;
   logic             err;
   logic [S_SZ-1:0]  err_stat;
   logic [C_SZ-1:0]  m_cmd;
   logic [7:0]       m_dat;
   logic             m_ws;
   logic [S_SZ-1:0]  m_stat;
   logic [7:0]       m_dat_out;

   modport slave (
      input  req_vld, req_rd, req_sla, req_reg, req_len, wr_dat, wr_vld,
             m_stat, m_dat_out,
      output req_rdy, wr_rdy, rd_dat, rd_vld, done, err, err_stat,
             m_cmd, m_dat, m_ws
   );

   modport master (
      output req_vld, req_rd, req_sla, req_reg, req_len, wr_dat, wr_vld,
             m_stat, m_dat_out,
      input  req_rdy, wr_rdy, rd_dat, rd_vld, done, err, err_stat,
             m_cmd, m_dat, m_ws
   );
endinterface
`default_nettype wire

// File: rtl/i2c_reg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_reg_seq
//  Description : Command sequencer for i2c_master. Converts one register
//                read/write request into START+address, register index,
//                data bytes, optional repeated START and STOP, using the
//                master's cmd / ws / stat handshake. Performs error recovery
//                (clear status, release the bus with STOP) and reports a
//                per-request done/err/err_stat result.
//                Ports:
//                  clk      : system clock (shared with i2c_master)
//                  aresetn  : synchronous active-low reset
//                  bus      : i2c_reg_seq_if.slave (host + master signals)
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_reg_seq #(
   parameter int LEN_W   = 8,
   parameter int TMO_CYC = 200000
) (
   input  logic         clk,
   input  logic         aresetn,
   i2c_reg_seq_if.slave bus
);
   localparam int C_SZ = 6;
   localparam int S_SZ = 4;

   // i2c_master command bits
   localparam logic [C_SZ-1:0] C_STRT = 6'b000001;
   localparam logic [C_SZ-1:0] C_STOP = 6'b000010;
   localparam logic [C_SZ-1:0] C_READ = 6'b000100;
   localparam logic [C_SZ-1:0] C_WRTE = 6'b001000;
   localparam logic [C_SZ-1:0] C_NACK = 6'b010000;
   localparam logic [C_SZ-1:0] C_CLRS = 6'b100000;

   // i2c_master status bit positions (bit 3 = arbitration lost, captured only)
   localparam int SB_DON = 0;
   localparam int SB_ERR = 1;
   localparam int SB_BBY = 2;

   localparam bit TMO_EN = (TMO_CYC != 0);
   localparam int TMO_W  = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_ISSUE = 3'd2,
      ST_GAP   = 3'd3,
      ST_POLL  = 3'd4
   } state_e;

   // Which command of the transfer is currently in flight
   typedef enum logic [2:0] {
      SP_ADDR  = 3'd0,
      SP_REG   = 3'd1,
      SP_RADDR = 3'd2,
      SP_DATA  = 3'd3,
      SP_CLRS  = 3'd4,
      SP_RSTOP = 3'd5
   } step_e;

   state_e           state_q,    state_d;
   step_e            step_q,     step_d;
   logic             rd_q,       rd_d;
   logic [6:0]       sla_q,      sla_d;
   logic [7:0]       reg_q,      reg_d;
   logic [LEN_W-1:0] cnt_q,      cnt_d;
   logic [C_SZ-1:0]  m_cmd_q,    m_cmd_d;
   logic [7:0]       m_dat_q,    m_dat_d;
   logic [7:0]       rd_dat_q,   rd_dat_d;
   logic             rd_vld_q,   rd_vld_d;
   logic             done_q,     done_d;
   logic             err_q,      err_d;
   logic [S_SZ-1:0]  err_stat_q, err_stat_d;
   logic [TMO_W-1:0] tmo_q,      tmo_d;

   logic             last;
   logic             last_next;
   logic [LEN_W-1:0] cnt_dec;
   logic             st_don;
   logic             st_err;
   logic             tmo_hit;

   assign last      = (cnt_q == LEN_W'(1));
   assign cnt_dec   = cnt_q - 1'b1;
   assign last_next = (cnt_dec == LEN_W'(1));
   assign st_don    = bus.m_stat[SB_DON];
   assign st_err    = bus.m_stat[SB_ERR];
   assign tmo_hit   = TMO_EN && (tmo_q == TMO_LAST);

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_q    <= ST_IDLE;
         step_q     <= SP_ADDR;
         rd_q       <= 1'b0;
         sla_q      <= '0;
         reg_q      <= '0;
         cnt_q      <= '0;
         m_cmd_q    <= '0;
         m_dat_q    <= '0;
         rd_dat_q   <= '0;
         rd_vld_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_stat_q <= '0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         rd_q       <= rd_d;
         sla_q      <= sla_d;
         reg_q      <= reg_d;
         cnt_q      <= cnt_d;
         m_cmd_q    <= m_cmd_d;
         m_dat_q    <= m_dat_d;
         rd_dat_q   <= rd_dat_d;
         rd_vld_q   <= rd_vld_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_stat_q <= err_stat_d;
         tmo_q      <= tmo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      rd_d       = rd_q;
      sla_d      = sla_q;
      reg_d      = reg_q;
      cnt_d      = cnt_q;
      m_cmd_d    = m_cmd_q;
      m_dat_d    = m_dat_q;
      rd_dat_d   = rd_dat_q;
      rd_vld_d   = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_stat_d = err_stat_q;
      tmo_d      = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_vld) begin
               rd_d    = bus.req_rd;
               sla_d   = bus.req_sla;
               reg_d   = bus.req_reg;
               cnt_d   = bus.req_len;
               step_d  = SP_ADDR;
               m_cmd_d = C_STRT | C_WRTE;
               m_dat_d = {bus.req_sla, 1'b0};
               state_d = ST_ISSUE;
            end
         end

         ST_FETCH: begin
            // Bus stays held for as long as the host withholds data
            if (bus.wr_vld) begin
               m_dat_d = bus.wr_dat;
               m_cmd_d = C_WRTE | (last ? C_STOP : '0);
               state_d = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            state_d = ST_GAP;
         end

         ST_GAP: begin
            // CLRS is fire-and-forget; decide on the bus release straight away
            if (step_q == SP_CLRS) begin
               if (err_stat_q[SB_BBY]) begin
                  m_cmd_d = C_STOP;
                  m_dat_d = '0;
                  step_d  = SP_RSTOP;
                  state_d = ST_ISSUE;
               end else begin
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_POLL;
            end
         end

         ST_POLL: begin
            if (step_q == SP_RSTOP) begin
               // Outcome of the recovery STOP does not change the result
               if (st_don || st_err || tmo_hit) begin
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end else if (st_err || (!st_don && tmo_hit)) begin
               // Error wins over a simultaneous DON
               err_stat_d = st_err ? bus.m_stat : '1;
               m_cmd_d    = C_CLRS;
               m_dat_d    = '0;
               step_d     = SP_CLRS;
               state_d    = ST_ISSUE;
            end else if (st_don) begin
               case (step_q)
                  SP_ADDR: begin
                     m_cmd_d = C_WRTE | ((cnt_q == '0) ? C_STOP : '0);
                     m_dat_d = reg_q;
                     step_d  = SP_REG;
                     state_d = ST_ISSUE;
                  end
                  SP_REG: begin
                     if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                     end else if (rd_q) begin
                        m_cmd_d = C_STRT | C_WRTE;
                        m_dat_d = {sla_q, 1'b1};
                        step_d  = SP_RADDR;
                        state_d = ST_ISSUE;
                     end else begin
                        step_d  = SP_DATA;
                        state_d = ST_FETCH;
                     end
                  end
                  SP_RADDR: begin
                     m_cmd_d = C_READ | (last ? (C_NACK | C_STOP) : '0);
                     step_d  = SP_DATA;
                     state_d = ST_ISSUE;
                  end
                  SP_DATA: begin
                     if (rd_q) begin
                        rd_dat_d = bus.m_dat_out;
                        rd_vld_d = 1'b1;
                     end
                     // Counter stops at 1 so a full-scale length never wraps
                     if (last) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                     end else begin
                        cnt_d = cnt_dec;
                        if (rd_q) begin
                           m_cmd_d = C_READ | (last_next ? (C_NACK | C_STOP) : '0);
                           state_d = ST_ISSUE;
                        end else begin
                           state_d = ST_FETCH;
                        end
                     end
                  end
                  default: begin
                     state_d = ST_IDLE;
                  end
               endcase
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.req_rdy  = (state_q == ST_IDLE);
   assign bus.wr_rdy   = (state_q == ST_FETCH);
   assign bus.m_ws     = (state_q == ST_ISSUE);
   assign bus.m_cmd    = m_cmd_q;
   assign bus.m_dat    = m_dat_q;
   assign bus.rd_dat   = rd_dat_q;
   assign bus.rd_vld   = rd_vld_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.err_stat = err_stat_q;
endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_reg_seq
//  Description : Testbench for i2c_reg_seq. Behavioural i2c_master + slave
//                model, randomized requests, expected commands / read bytes /
//                results queued at issue time and checked by a monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_reg_seq;
   localparam int LEN_W = 8;
   localparam int TMO   = 50;

   localparam logic [5:0] C_STRT = 6'h01;
   localparam logic [5:0] C_STOP = 6'h02;
   localparam logic [5:0] C_READ = 6'h04;
   localparam logic [5:0] C_WRTE = 6'h08;
   localparam logic [5:0] C_NACK = 6'h10;
   localparam logic [5:0] C_CLRS = 6'h20;
   localparam logic [3:0] S_DON  = 4'h1;
   localparam logic [3:0] S_ERR  = 4'h2;
   localparam logic [3:0] S_BBY  = 4'h4;
   localparam logic [6:0] SLA    = 7'h3a;

   logic clk     = 1'b0;
   logic aresetn = 1'b0;
   always #5 clk = ~clk;

   i2c_reg_seq_if #(.LEN_W(LEN_W)) bus ();

   i2c_reg_seq #(.LEN_W(LEN_W), .TMO_CYC(TMO)) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // ---------------- scoreboard queues ----------------
   logic [13:0] exp_cmd_q[$];   // {cmd, dat}
   logic [7:0]  exp_rd_q[$];
   logic [4:0]  exp_done_q[$];  // {err, err_stat}
   logic [7:0]  wr_src_q[$];
   logic [7:0]  fixed_q[$];
   int          ws_cyc[$];

   // reference memory (updated when a write request is issued)
   logic [7:0]  mem_ref [256];
   // slave memory (updated only by what actually crosses the bus)
   logic [7:0]  mem     [256];

   int cyc         = 0;
   int done_cnt    = 0;
   int consumed    = 0;
   int wr_idx      = 0;
   int stall_idx   = -1;
   int stall_len   = 0;
   int stall_left  = 0;
   int ws_in_stall = 0;
   bit stalling    = 1'b0;
   bit hang        = 1'b0;

   // ---------------- i2c_master + slave behavioural model ----------------
   logic [3:0] stat;
   logic [7:0] dout;
   logic [5:0] mc;
   logic [7:0] md;
   logic [7:0] ptr;
   int         pend;
   bit         bby;
   bit         first_wr;

   task automatic exec_cmd();
      bit ok = 1'b1;
      if ((mc & C_STRT) != 0) begin
         bby = 1'b1;
         if (md[7:1] != SLA) ok = 1'b0;
         else first_wr = 1'b1;
      end else if ((mc & C_WRTE) != 0) begin
         if (first_wr) begin
            ptr      = md;
            first_wr = 1'b0;
         end else begin
            mem[ptr] = md;
            ptr      = ptr + 8'd1;
         end
      end
      if ((mc & C_READ) != 0) begin
         dout = mem[ptr];
         ptr  = ptr + 8'd1;
      end
      if (ok && ((mc & C_STOP) != 0)) bby = 1'b0;
      stat = (bby ? S_BBY : 4'h0) | (ok ? S_DON : S_ERR);
   endtask

   always @(negedge clk) begin
      if (!aresetn) begin
         pend = 0; stat = '0; dout = '0; bby = 1'b0; first_wr = 1'b0;
         ptr = '0; mc = '0; md = '0;
      end else if (bus.m_ws) begin
         mc   = bus.m_cmd;
         md   = bus.m_dat;
         stat = stat & ~(S_DON | S_ERR);
         if (mc == C_CLRS || hang) pend = 0;
         else pend = $urandom_range(1, 6);
      end else if (pend > 0) begin
         pend--;
         if (pend == 0) exec_cmd();
      end
      bus.m_stat    = stat;
      bus.m_dat_out = dout;
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [13:0] e;
      logic [4:0]  d;
      cyc++;
      if (aresetn) begin
         if (bus.m_ws) begin
            ws_cyc.push_back(cyc);
            if (stalling && stall_left < stall_len - 1) ws_in_stall++;
            if (exp_cmd_q.size() == 0) fail_now("unexpected_ws");
            else begin
               e = exp_cmd_q.pop_front();
               check("m_cmd", 32'(bus.m_cmd), 32'(e[13:8]));
               if ((e[13:8] & C_WRTE) != 0) check("m_dat", 32'(bus.m_dat), 32'(e[7:0]));
            end
         end
         if (bus.rd_vld) begin
            if (exp_rd_q.size() == 0) fail_now("unexpected_rd_vld");
            else check("rd_dat", 32'(bus.rd_dat), 32'(exp_rd_q.pop_front()));
         end
         if (bus.done) begin
            if (exp_done_q.size() == 0) fail_now("unexpected_done");
            else begin
               d = exp_done_q.pop_front();
               check("err", 32'(bus.err), 32'(d[4]));
               if (d[4]) check("err_stat", 32'(bus.err_stat), 32'(d[3:0]));
               check("cmds_left_at_done", exp_cmd_q.size(), 0);
               check("rd_left_at_done", exp_rd_q.size(), 0);
            end
            done_cnt++;
         end
      end
   end

   // ---------------- write-data source ----------------
   initial begin
      bit take;
      bus.wr_vld = 1'b0;
      bus.wr_dat = '0;
      forever begin
         @(negedge clk);
         take = bus.wr_vld && bus.wr_rdy && aresetn;
         @(posedge clk);
         #1;
         if (take && wr_src_q.size() > 0) begin
            void'(wr_src_q.pop_front());
            consumed++;
            wr_idx++;
         end
         if (stall_left > 0 && wr_idx == stall_idx && wr_src_q.size() > 0) begin
            stalling   = 1'b1;
            stall_left--;
            bus.wr_vld = 1'b0;
         end else begin
            stalling = 1'b0;
            if (wr_src_q.size() > 0 && (stall_idx >= 0 || $urandom_range(0, 3) != 0)) begin
               bus.wr_vld = 1'b1;
               bus.wr_dat = wr_src_q[0];
            end else begin
               bus.wr_vld = 1'b0;
            end
         end
      end
   end

   // ---------------- reference model: expected bus sequence ----------------
   function automatic logic [13:0] cw(input logic [5:0] c, input logic [7:0] d);
      return {c, d};
   endfunction

   // returns number of write bytes the DUT should consume
   function automatic int build_expect(input bit rd, input logic [6:0] sla,
                                       input logic [7:0] rg, input int len);
      logic [7:0] b;
      logic [7:0] a;
      exp_cmd_q.push_back(cw(C_STRT | C_WRTE, {sla, 1'b0}));
      if (!rd) begin
         for (int i = 0; i < len; i++) begin
            b = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
            wr_src_q.push_back(b);
         end
      end
      if (sla != SLA) begin
         // address NACK: status clear, then STOP because the bus is still owned
         exp_cmd_q.push_back(cw(C_CLRS, 8'h00));
         exp_cmd_q.push_back(cw(C_STOP, 8'h00));
         exp_done_q.push_back({1'b1, S_ERR | S_BBY});
         return 0;
      end
      exp_cmd_q.push_back(cw(C_WRTE | ((len == 0) ? C_STOP : 6'h0), rg));
      if (rd) begin
         if (len > 0) exp_cmd_q.push_back(cw(C_STRT | C_WRTE, {sla, 1'b1}));
         for (int i = 0; i < len; i++) begin
            a = rg + 8'(i);
            exp_cmd_q.push_back(cw((i == len - 1) ? (C_READ | C_NACK | C_STOP) : C_READ, 8'h00));
            exp_rd_q.push_back(mem_ref[a]);
         end
      end else begin
         for (int i = 0; i < len; i++) begin
            a = rg + 8'(i);
            exp_cmd_q.push_back(cw(C_WRTE | ((i == len - 1) ? C_STOP : 6'h0), wr_src_q[i]));
            mem_ref[a] = wr_src_q[i];
         end
      end
      exp_done_q.push_back({1'b0, 4'h0});
      return rd ? 0 : len;
   endfunction

   task automatic issue_req(input bit rd, input logic [6:0] sla, input logic [7:0] rg, input int len);
      int t = 0;
      @(posedge clk); #1;
      while (!bus.req_rdy && t < 20000) begin
         @(posedge clk); #1;
         t++;
      end
      if (!bus.req_rdy) fail_now("req_rdy_wait_timeout");
      bus.req_rd  = rd;
      bus.req_sla = sla;
      bus.req_reg = rg;
      bus.req_len = LEN_W'(len);
      bus.req_vld = 1'b1;
      @(posedge clk); #1;
      // garbage request while busy must be ignored
      bus.req_rd  = ~rd;
      bus.req_sla = 7'h55;
      bus.req_reg = 8'haa;
      @(negedge clk);
      check("req_rdy_busy", 32'(bus.req_rdy), 0);
      repeat (3) @(posedge clk);
      #1 bus.req_vld = 1'b0;
   endtask

   task automatic wait_done(input int start);
      int t = 0;
      while (done_cnt == start && t < 30000) begin
         @(negedge clk);
         t++;
      end
      if (done_cnt == start) fail_now("done_wait_timeout");
   endtask

   task automatic run_req(input bit rd, input logic [6:0] sla, input logic [7:0] rg,
                          input int len, input int s_idx, input int s_len);
      int exp_wr;
      int start;
      consumed   = 0;
      wr_idx     = 0;
      stall_idx  = s_idx;
      stall_len  = s_len;
      stall_left = s_len;
      exp_wr     = build_expect(rd, sla, rg, len);
      start      = done_cnt;
      issue_req(rd, sla, rg, len);
      wait_done(start);
      wr_src_q.delete();
      stall_left = 0;
      stall_idx  = -1;
      repeat (2) @(posedge clk);
      check("wr_consumed", consumed, exp_wr);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int start;
      bus.req_vld = 1'b0;
      bus.req_rd  = 1'b0;
      bus.req_sla = '0;
      bus.req_reg = '0;
      bus.req_len = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'($urandom);
         mem_ref[i] = mem[i];
      end
      mem[2] = 8'h33; mem_ref[2] = 8'h33;

      repeat (4) @(posedge clk);
      #1 aresetn = 1'b1;
      @(negedge clk);
      check("rst_req_rdy",  32'(bus.req_rdy), 1);
      check("rst_m_cmd",    32'(bus.m_cmd), 0);
      check("rst_m_dat",    32'(bus.m_dat), 0);
      check("rst_err_stat", 32'(bus.err_stat), 0);
      check("rst_m_ws",     32'(bus.m_ws), 0);
      check("rst_done",     32'(bus.done), 0);
      check("rst_err",      32'(bus.err), 0);
      check("rst_wr_rdy",   32'(bus.wr_rdy), 0);
      check("rst_rd_vld",   32'(bus.rd_vld), 0);

      // directed cases
      fixed_q = '{8'h11, 8'h22};
      run_req(1'b0, SLA, 8'h00, 2, -1, 0);
      run_req(1'b1, SLA, 8'h00, 3, -1, 0);
      run_req(1'b0, 7'h3b, 8'h10, 2, -1, 0);
      ws_in_stall = 0;
      run_req(1'b0, SLA, 8'h40, 3, 1, 500);
      check("ws_during_stall", ws_in_stall, 0);
      run_req(1'b0, SLA, 8'h20, 0, -1, 0);
      run_req(1'b1, SLA, 8'h20, 0, -1, 0);
      run_req(1'b1, SLA, 8'h40, 1, -1, 0);
      run_req(1'b1, 7'h3b, 8'h00, 4, -1, 0);
      run_req(1'b0, SLA, 8'h80, 255, -1, 0);
      run_req(1'b1, SLA, 8'h80, 255, -1, 0);

      // randomized requests
      for (int n = 0; n < 25; n++) begin
         run_req(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 7'h3b : SLA,
                 8'($urandom), $urandom_range(0, 12), -1, 0);
      end

      // master never completes: timeout path
      hang = 1'b1;
      exp_cmd_q.push_back(cw(C_STRT | C_WRTE, {SLA, 1'b0}));
      exp_cmd_q.push_back(cw(C_CLRS, 8'h00));
      exp_cmd_q.push_back(cw(C_STOP, 8'h00));
      exp_done_q.push_back({1'b1, 4'hf});
      wr_src_q = '{8'h5a, 8'ha5};
      consumed = 0;
      wr_idx   = 0;
      ws_cyc.delete();
      start = done_cnt;
      issue_req(1'b0, SLA, 8'h01, 2);
      wait_done(start);
      wr_src_q.delete();
      repeat (2) @(posedge clk);
      check("tmo_wr_consumed", consumed, 0);
      check("tmo_ws_count", ws_cyc.size(), 3);
      if (ws_cyc.size() >= 2) check("tmo_clrs_latency", ws_cyc[1] - ws_cyc[0], TMO + 2);
      hang = 1'b0;

      // reset in the middle of a read, then a clean write
      void'(build_expect(1'b1, SLA, 8'h80, 6));
      issue_req(1'b1, SLA, 8'h80, 6);
      repeat (10) @(posedge clk);
      #1 aresetn = 1'b0;
      exp_cmd_q.delete();
      exp_rd_q.delete();
      exp_done_q.delete();
      repeat (3) @(posedge clk);
      #1 aresetn = 1'b1;
      @(negedge clk);
      check("post_rst_req_rdy", 32'(bus.req_rdy), 1);
      check("post_rst_m_ws",    32'(bus.m_ws), 0);
      check("post_rst_m_cmd",   32'(bus.m_cmd), 0);
      run_req(1'b0, SLA, 8'h07, 4, -1, 0);
      run_req(1'b1, SLA, 8'h07, 4, -1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
